// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: one-entry pipeline stage with a skid register, so in_ready comes straight from a flop.
module pipe_skid_stage #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] NOP_VAL = {WIDTH{1'b0}},
  parameter bit BYPASS = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       level
);
  if (BYPASS) begin : g_bypass
    wire unused_clk = clock ^ reset;
    assign out_valid = in_valid & ~flush;
    assign in_ready  = out_ready | flush;
    assign out_data  = (flush | ~in_valid) ? NOP_VAL : in_data;
    assign level     = 2'd0;
  end else begin : g_reg
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    state_t state = EMPTY;
    state_t state_n;
    logic [WIDTH-1:0] main_q = NOP_VAL;
    logic [WIDTH-1:0] skid_q = NOP_VAL;
    logic [WIDTH-1:0] main_n, skid_n;
    logic ready_q = 1'b1;
    logic in_fire, out_fire;
    assign in_ready  = ready_q;
    assign out_valid = state != EMPTY;
    assign out_data  = main_q;
    assign level     = state;
    assign in_fire   = in_valid & ready_q;
    assign out_fire  = out_valid & out_ready;
    always_comb begin
      state_n = state;
      main_n  = main_q;
      skid_n  = skid_q;
      if (flush) begin
        state_n = EMPTY;
        main_n  = NOP_VAL;
      end else if (state == EMPTY) begin
        if (in_fire) begin
          state_n = ONE;
          main_n  = in_data;
        end
      end else if (state == ONE) begin
        if (in_fire && !out_fire) begin
          state_n = FULL;
          skid_n  = in_data;
        end else if (in_fire) begin
          main_n = in_data;
        end else if (out_fire) begin
          state_n = EMPTY;
          main_n  = NOP_VAL;
        end
      end else if (out_fire) begin
        state_n = ONE;
        main_n  = skid_q;
      end
    end
    always_ff @(posedge clock) begin
      if (reset) begin
        state   <= EMPTY;
        main_q  <= NOP_VAL;
        skid_q  <= NOP_VAL;
        ready_q <= 1'b1;
      end else begin
        state   <= state_n;
        main_q  <= main_n;
        skid_q  <= skid_n;
        ready_q <= state_n != FULL;
      end
    end
  end
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: vector table plus scoreboard FIFO model for the registered stage, direct checks for bypass.
module tb_pipe_skid_stage;
  localparam logic [31:0] B_NOP = 32'hDEAD_BEEF;
  logic clock = 1'b0;
  logic reset, flush, in_valid, out_ready, in_ready, out_valid;
  logic [31:0] in_data, out_data;
  logic [1:0] level;
  logic b_flush, b_in_valid, b_out_ready, b_in_ready, b_out_valid;
  logic [31:0] b_in_data, b_out_data;
  logic [1:0] b_level;
  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic r, f, iv;
    logic [31:0] d;
    logic ordy;
    logic e_ir, e_ov;
    logic [31:0] e_od;
    logic [1:0] e_lv;
  } vec_t;
  vec_t vecs[$];

  always #5 clock = ~clock;

  pipe_skid_stage #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .level(level)
  );

  pipe_skid_stage #(.WIDTH(32), .NOP_VAL(B_NOP), .BYPASS(1'b1)) dut_b (
    .clock(clock), .reset(1'b0), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .level(b_level)
  );

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endfunction

  // Structural invariants of the registered stage, every cycle.
  always @(negedge clock) begin
    chk("inv_in_ready", 32'(in_ready), 32'(level != 2'd2));
    chk("inv_out_valid", 32'(out_valid), 32'(level != 2'd0));
    if (!out_valid) chk("inv_nop", out_data, 32'd0);
  end

  task automatic step(input logic r, input logic f, input logic iv, input logic [31:0] d, input logic ordy);
    logic ofire, ifire;
    reset = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    @(posedge clock);
    ofire = ordy && sb.size() > 0;
    ifire = iv && sb.size() < 2;
    if (r || f) sb.delete();
    else begin
      if (ofire) void'(sb.pop_front());
      if (ifire) sb.push_back(d);
    end
    #1;
    chk("sb_level", 32'(level), 32'(sb.size()));
    chk("sb_in_ready", 32'(in_ready), 32'(sb.size() < 2));
    chk("sb_out_valid", 32'(out_valid), 32'(sb.size() > 0));
    chk("sb_out_data", out_data, sb.size() > 0 ? sb[0] : 32'd0);
  endtask

  function automatic vec_t v(logic r, logic f, logic iv, logic [31:0] d, logic ordy,
                             logic ir, logic ov, logic [31:0] od, logic [1:0] lv);
    vec_t x;
    x.r = r; x.f = f; x.iv = iv; x.d = d; x.ordy = ordy;
    x.e_ir = ir; x.e_ov = ov; x.e_od = od; x.e_lv = lv;
    return x;
  endfunction

  initial begin
    // reset
    vecs.push_back(v(1, 0, 0, 0, 0, 1, 0, 0, 0));
    // streaming 1..4 with out_ready high
    vecs.push_back(v(0, 0, 1, 1, 1, 1, 1, 1, 1));
    vecs.push_back(v(0, 0, 1, 2, 1, 1, 1, 2, 1));
    vecs.push_back(v(0, 0, 1, 3, 1, 1, 1, 3, 1));
    vecs.push_back(v(0, 0, 1, 4, 1, 1, 1, 4, 1));
    vecs.push_back(v(0, 0, 0, 0, 1, 1, 0, 0, 0));
    // backpressure; 0xF offered while FULL must be refused
    vecs.push_back(v(0, 0, 1, 32'hA, 0, 1, 1, 32'hA, 1));
    vecs.push_back(v(0, 0, 1, 32'hB, 0, 0, 1, 32'hA, 2));
    vecs.push_back(v(0, 0, 1, 32'hF, 0, 0, 1, 32'hA, 2));
    vecs.push_back(v(0, 0, 0, 0, 1, 1, 1, 32'hB, 1));
    vecs.push_back(v(0, 0, 0, 0, 1, 1, 0, 0, 0));
    // flush in FULL with 0xC offered
    vecs.push_back(v(0, 0, 1, 32'hA, 0, 1, 1, 32'hA, 1));
    vecs.push_back(v(0, 0, 1, 32'hB, 0, 0, 1, 32'hA, 2));
    vecs.push_back(v(0, 1, 1, 32'hC, 0, 1, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 1, 0, 0, 0));
    // flush in ONE with simultaneous in_fire and out_fire
    vecs.push_back(v(0, 0, 1, 32'hD, 0, 1, 1, 32'hD, 1));
    vecs.push_back(v(0, 1, 1, 32'hE, 1, 1, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 1, 0, 0, 0));
    // reset in ONE, then 0x5 emerges alone
    vecs.push_back(v(0, 0, 1, 32'h6, 0, 1, 1, 32'h6, 1));
    vecs.push_back(v(1, 1, 1, 32'h7, 0, 1, 0, 0, 0));
    vecs.push_back(v(0, 0, 1, 32'h5, 0, 1, 1, 32'h5, 1));
    vecs.push_back(v(0, 0, 0, 0, 1, 1, 0, 0, 0));
    // reset mid-FULL drops both
    vecs.push_back(v(0, 0, 1, 32'h8, 0, 1, 1, 32'h8, 1));
    vecs.push_back(v(0, 0, 1, 32'h9, 0, 0, 1, 32'h8, 2));
    vecs.push_back(v(1, 0, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 1, 0, 0, 0));
    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].f, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      chk("vec_in_ready", 32'(in_ready), 32'(vecs[i].e_ir));
      chk("vec_out_valid", 32'(out_valid), 32'(vecs[i].e_ov));
      chk("vec_out_data", out_data, vecs[i].e_od);
      chk("vec_level", 32'(level), 32'(vecs[i].e_lv));
    end
    // randomised traffic against the scoreboard
    for (int i = 0; i < 400; i++)
      step(1'b0, $urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0));
    // bypass instance, purely combinational
    b_flush = 0; b_in_valid = 1; b_in_data = 32'h7; b_out_ready = 0;
    #1;
    chk("byp_out_valid", 32'(b_out_valid), 32'd1);
    chk("byp_out_data", b_out_data, 32'h7);
    chk("byp_in_ready", 32'(b_in_ready), 32'd0);
    chk("byp_level", 32'(b_level), 32'd0);
    b_flush = 1;
    #1;
    chk("byp_flush_valid", 32'(b_out_valid), 32'd0);
    chk("byp_flush_ready", 32'(b_in_ready), 32'd1);
    chk("byp_flush_data", b_out_data, B_NOP);
    b_flush = 0; b_in_valid = 0; b_out_ready = 1;
    #1;
    chk("byp_idle_valid", 32'(b_out_valid), 32'd0);
    chk("byp_idle_data", b_out_data, B_NOP);
    chk("byp_idle_ready", 32'(b_in_ready), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
